// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM link types and slot constants
package tdm_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   localparam logic [SLOT_W-1:0] FIRST_SLOT = SLOT_W'(0);
   localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(NUM_SLOTS - 1);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - slot index counter with enable, load-to-one, clear and wrap flag
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load_one,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot,
   output logic              wrap
);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;

   // Next slot: clear beats a marker reload, which beats a plain increment
   always_comb begin
      slot_d = slot_q;
      if (clr) begin
         slot_d = FIRST_SLOT;
      end else if (load_one) begin
         slot_d = SLOT_W'(1);
      end else if (en) begin
         slot_d = SLOT_W'(slot_q + SLOT_W'(1));
      end
   end

   // Slot register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= FIRST_SLOT;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot = slot_q;
   // High while sitting on the last slot, i.e. the next increment wraps
   assign wrap = (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demultiplexer.sv
// rtl/tdm_demultiplexer.sv - 4:1 TDM receiver: frame lock, channel rebuild and status pulses
module tdm_demultiplexer
   import tdm_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              serialIn,
   input  logic              inValid,
   input  logic              frameSync,
   output logic              out0,
   output logic              out1,
   output logic              out2,
   output logic              out3,
   output logic [SLOT_W-1:0] slot,
   output logic              locked,
   output logic              frameValid,
   output logic              syncErr
);

   if (NUM_SLOTS != 4 || SLOT_W != 2 || SLOT_W != tdm_pkg::SLOT_W) begin : g_param_check
      $error("tdm_demultiplexer supports only NUM_SLOTS=4, SLOT_W=2");
   end

   tdm_state_e        state_q, state_d;
   logic [2:0]        shadow_q, shadow_d;
   logic [3:0]        out_q, out_d;
   logic              frame_valid_q, frame_valid_d;
   logic              sync_err_q, sync_err_d;

   logic              cnt_en;
   logic              cnt_load_one;
   logic              cnt_clr;
   logic [SLOT_W-1:0] cnt_slot;
   logic              cnt_wrap;

   tdm_slot_counter u_slot_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (cnt_en),
      .load_one (cnt_load_one),
      .clr      (cnt_clr),
      .slot     (cnt_slot),
      .wrap     (cnt_wrap)
   );

   // Frame alignment: decide what each valid sample does to state, shadow and outputs
   always_comb begin
      state_d       = state_q;
      shadow_d      = shadow_q;
      out_d         = out_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      cnt_en        = 1'b0;
      cnt_load_one  = 1'b0;
      cnt_clr       = 1'b0;

      if (inValid) begin
         unique case (state_q)
            HUNT: begin
               // Unmarked samples are dropped quietly while hunting
               if (frameSync) begin
                  shadow_d[0]  = serialIn;
                  cnt_load_one = 1'b1;
                  state_d      = LOCKED;
               end
            end
            LOCKED: begin
               if (cnt_slot == FIRST_SLOT) begin
                  if (frameSync) begin
                     shadow_d[0]  = serialIn;
                     cnt_load_one = 1'b1;
                  end else begin
                     sync_err_d = 1'b1;
                     cnt_clr    = 1'b1;
                     state_d    = HUNT;
                  end
               end else if (frameSync) begin
                  // Early marker: restart the frame on this sample, keep old outputs
                  sync_err_d   = 1'b1;
                  shadow_d[0]  = serialIn;
                  cnt_load_one = 1'b1;
               end else if (cnt_wrap) begin
                  out_d         = {serialIn, shadow_q};
                  frame_valid_d = 1'b1;
                  cnt_en        = 1'b1;
               end else begin
                  if (cnt_slot == SLOT_W'(1)) begin
                     shadow_d[1] = serialIn;
                  end else begin
                     shadow_d[2] = serialIn;
                  end
                  cnt_en = 1'b1;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

   // State, shadow, channel outputs and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= HUNT;
         shadow_q      <= 3'b000;
         out_q         <= 4'b0000;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shadow_q      <= shadow_d;
         out_q         <= out_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
      end
   end

   assign out0       = out_q[0];
   assign out1       = out_q[1];
   assign out2       = out_q[2];
   assign out3       = out_q[3];
   assign slot       = cnt_slot;
   assign locked     = (state_q == LOCKED);
   assign frameValid = frame_valid_q;
   assign syncErr    = sync_err_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb/tb_tdm_demultiplexer.sv - directed self-checking bench for tdm_demultiplexer
module tb_tdm_demultiplexer;

   logic       clk;
   logic       rst_n;
   logic       serialIn;
   logic       inValid;
   logic       frameSync;
   logic       out0, out1, out2, out3;
   logic [1:0] slot;
   logic       locked;
   logic       frameValid;
   logic       syncErr;

   int n_checks;
   int n_fails;
   int cyc;
   int fv_first;
   int fv_second;

   wire [3:0] outs = {out3, out2, out1, out0};

   tdm_demultiplexer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serialIn   (serialIn),
      .inValid    (inValid),
      .frameSync  (frameSync),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3),
      .slot       (slot),
      .locked     (locked),
      .frameValid (frameValid),
      .syncErr    (syncErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 ns after the rising edge
   task automatic step(input logic v, input logic fs, input logic d);
      @(negedge clk);
      inValid   = v;
      frameSync = fs;
      serialIn  = d;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      cyc       = 0;
      fv_first  = -1;
      fv_second = -1;
      rst_n     = 1'b0;
      inValid   = 1'b0;
      frameSync = 1'b0;
      serialIn  = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_outs", outs, 4'h0);
      check("rst_locked", locked, 1'b0);
      check("rst_slot", slot, 2'd0);
      check("rst_fv", frameValid, 1'b0);
      check("rst_se", syncErr, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 1,0,1,1 with no gaps
      step(1, 1, 1);
      check("f1_locked", locked, 1'b1);
      check("f1_slot1", slot, 2'd1);
      step(1, 0, 0);
      step(1, 0, 1);
      check("f1_slot3", slot, 2'd3);
      check("f1_fv_early", frameValid, 1'b0);
      step(1, 0, 1);
      check("f1_fv", frameValid, 1'b1);
      check("f1_outs", outs, 4'b1101);
      check("f1_slot_wrap", slot, 2'd0);
      step(0, 0, 0);
      check("f1_fv_drop", frameValid, 1'b0);

      // Same frame with a 3-cycle gap between slots 1 and 2
      step(1, 1, 1);
      step(1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1);
         check("gap_slot_hold", slot, 2'd2);
         check("gap_fv", frameValid, 1'b0);
         check("gap_se", syncErr, 1'b0);
      end
      step(1, 0, 1);
      check("gap_fv_s2", frameValid, 1'b0);
      step(1, 0, 1);
      check("gap_fv", frameValid, 1'b1);
      check("gap_outs", outs, 4'b1101);

      // Frame 0,1,1,0 with an early marker on slot 2
      step(1, 1, 0);
      step(1, 0, 1);
      step(1, 1, 1);
      check("early_se", syncErr, 1'b1);
      check("early_fv", frameValid, 1'b0);
      check("early_outs", outs, 4'b1101);
      check("early_slot", slot, 2'd1);
      check("early_locked", locked, 1'b1);
      step(0, 0, 0);
      check("early_se_drop", syncErr, 1'b0);
      // Finish the restarted frame: shadow0 came from the early-marker sample
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 0);
      check("restart_fv", frameValid, 1'b1);
      check("restart_outs", outs, 4'b0101);

      // Missing marker at slot 0 drops lock
      step(1, 0, 1);
      check("miss_se", syncErr, 1'b1);
      check("miss_locked", locked, 1'b0);
      check("miss_slot", slot, 2'd0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1);
         check("hunt_se", syncErr, 1'b0);
         check("hunt_fv", frameValid, 1'b0);
         check("hunt_outs", outs, 4'b0101);
         check("hunt_locked", locked, 1'b0);
      end

      // Async reset after slot 2 of a frame
      step(1, 1, 0);
      step(1, 0, 1);
      step(1, 0, 0);
      check("pre_rst_slot", slot, 2'd3);
      @(negedge clk);
      inValid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_outs", outs, 4'h0);
      check("arst_locked", locked, 1'b0);
      check("arst_slot", slot, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 1, 0);
      step(1, 0, 1);
      step(1, 0, 0);
      step(1, 0, 1);
      check("post_rst_fv", frameValid, 1'b1);
      check("post_rst_outs", outs, 4'b1010);

      // Back-to-back frames 1,1,1,1 then 0,0,0,0
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < 4; s++) begin
            step(1, (s == 0), (f == 0));
            check("b2b_se", syncErr, 1'b0);
            if (frameValid) begin
               if (fv_first < 0) fv_first = cyc;
               else fv_second = cyc;
            end
         end
         check("b2b_outs", outs, (f == 0) ? 4'hF : 4'h0);
      end
      check("b2b_fv_first_seen", (fv_first >= 0), 1'b1);
      check("b2b_fv_spacing", fv_second - fv_first, 4);
      step(0, 0, 0);
      check("b2b_fv_drop", frameValid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/tdm_demultiplexer.md
Name: tdm_demultiplexer

Overview:
- Receive end of the 4:1 time-division link. The transmit side drives a 1-bit line through a 4:1 multiplexer whose 2-bit address rotates 0,1,2,3 on each valid cycle.
- This block locks to the frame marker and rebuilds the four channel bits into registered outputs out0..out3. Slot k maps to outk, the same mapping as address k selecting ink on the transmit side.
- Reports frame completion, lock status and sync errors.

Parameters:
- NUM_SLOTS, 4, slots per frame. Fixed at 4 in this revision; the RTL must elaborate-check it.
- SLOT_W, 2, slot index width, equal to log2(NUM_SLOTS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serialIn  input  1  TDM data bit for the current slot.
- inValid  input  1  serialIn/frameSync are meaningful this cycle; low = gap, hold state.
- frameSync  input  1  marks the slot-0 sample; qualified by inValid.
- out0  output  1  registered channel 0 (slot 0) bit of last complete frame.
- out1  output  1  registered channel 1 bit.
- out2  output  1  registered channel 2 bit.
- out3  output  1  registered channel 3 bit.
- slot  output  SLOT_W  index the next valid sample will be stored into.
- locked  output  1  high in LOCKED state.
- frameValid  output  1  one-cycle pulse: out0..out3 just updated with a full frame.
- syncErr  output  1  one-cycle pulse on a frame-alignment violation.

Behaviour:
- Reset (async assert, sync-safe deassert): state HUNT; slot=0; shadow[2:0]=0; out0..3=0; locked=0; frameValid=0; syncErr=0.
- frameValid and syncErr are registered. Each is high for exactly one cycle after the qualifying edge and low otherwise.
- inValid=0: no state, slot, shadow or output change. Pulses deassert.
- HUNT:
  - A sample with inValid and frameSync stores serialIn into shadow[0], sets slot=1 and moves to LOCKED.
  - Samples without frameSync are discarded silently, with no syncErr.
- LOCKED, on each inValid sample at slot s:
  - s=0 with frameSync=1: normal. Store into shadow[0]; slot=1.
  - s=0 with frameSync=0: missing marker. Discard the sample, pulse syncErr, go to HUNT, slot=0.
  - s in 1..2 with frameSync=0: store into shadow[s]; slot=s+1.
  - s=3 with frameSync=0: frame complete. At this edge out0..out2 <= shadow[0..2] and out3 <= serialIn. Pulse frameValid; slot wraps to 0.
  - s in 1..3 with frameSync=1: early marker. Abandon the partial frame, leaving outputs unchanged. Pulse syncErr. Treat the sample as slot 0: shadow[0] <= serialIn, slot=1, stay LOCKED.
- Latency: out0..3 reflect a frame one clock after the slot-3 sample edge, coincident with frameValid=1. Outputs hold until the next complete frame.
- Gaps (inValid low) are legal anywhere inside a frame and do not break lock.
- Async reset mid-frame discards the partial frame immediately; outputs go to 0.
- frameValid and syncErr are never high in the same cycle.
- slot arithmetic is modulo NUM_SLOTS, unsigned, with no overflow flag.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, LOCKED};
  - NUM_SLOTS and SLOT_W constants;
  - constant FIRST_SLOT=0 and LAST_SLOT=NUM_SLOTS-1.
- The package is shared with the future transmit-side counter.
- One natural sub-module: tdm_slot_counter, a SLOT_W-bit counter with enable (inValid), sync load-to-1 (marker), clear and wrap flag. The FSM, shadow registers and output registers stay in the top.

Test Plan:
- Reset, then frameSync+inValid with serialIn sequence 1,0,1,1 over 4 consecutive valid cycles -> locked=1 after the first edge; frameValid pulses once; out0..3 = 1,0,1,1; slot=0.
- Same frame with inValid low for 3 cycles between slots 1 and 2 -> identical outputs; frameValid asserts only after the slot-3 sample; slot holds 2 during the gap.
- Locked, second frame 0,1,1,0 but with frameSync asserted again on slot 2 -> syncErr one cycle; outputs keep the previous 1,0,1,1; slot=1; locked stays 1.
- Locked, slot=0 sample arrives with frameSync=0 -> syncErr one cycle; locked=0; later valid samples without frameSync produce no outputs and no further syncErr.
- rst_n asserted asynchronously after slot 2 of a frame -> outputs 0, locked=0, slot=0 with no clock edge. After release, a full frame 0,1,0,1 decodes to out0..3 = 0,1,0,1.
- Back-to-back frames 1,1,1,1 then 0,0,0,0 with no gaps -> frameValid pulses exactly 4 cycles apart; outputs switch all-ones to all-zeros; syncErr never asserts.
